// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two Avalon-MM masters (m0 data, m1 fetch) sharing one RAM slave.
// One transaction per grant; the winning command is latched so the slave sees it stable through stalls.
`default_nettype none

module mem_bus_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e      state_q;
  logic        rr_ptr_q;
  logic [31:0] address_q;
  logic        read_q;
  logic        write_q;
  logic [31:0] writedata_q;
  logic [3:0]  byteenable_q;

  logic req0;
  logic req1;
  logic pick1;
  logic done0;
  logic done1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // m1 wins when alone, or on a tie when round-robin currently favours it.
  assign pick1 = req1 & (~req0 | ((FIXED_PRIORITY == 1'b0) & rr_ptr_q));

  assign done0 = (state_q == BUSY0) & ~waitrequest;
  assign done1 = (state_q == BUSY1) & ~waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            // A master asserting both read and write is treated as a write.
            if (pick1) begin
              state_q      <= BUSY1;
              address_q    <= m1_address;
              read_q       <= m1_read & ~m1_write;
              write_q      <= m1_write;
              writedata_q  <= m1_writedata;
              byteenable_q <= m1_byteenable;
            end else begin
              state_q      <= BUSY0;
              address_q    <= m0_address;
              read_q       <= m0_read & ~m0_write;
              write_q      <= m0_write;
              writedata_q  <= m0_writedata;
              byteenable_q <= m0_byteenable;
            end
          end
        end
        BUSY0, BUSY1: begin
          if (!waitrequest) begin
            state_q      <= IDLE;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            if (FIXED_PRIORITY == 1'b0) begin
              rr_ptr_q <= (state_q == BUSY0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The command register is cleared whenever the FSM sits in IDLE.
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

  assign m0_waitrequest = (state_q == BUSY0) ? waitrequest : 1'b1;
  assign m1_waitrequest = (state_q == BUSY1) ? waitrequest : 1'b1;
  assign m0_readdata    = done0 ? readdata : '0;
  assign m1_readdata    = done1 ? readdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table for the round-robin instance, plus hand sequences
// for asynchronous reset and the fixed-priority instance.
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_wait;
  logic [31:0] s_rdata;

  logic        w0, w1;
  logic [31:0] rd0, rd1, s_addr, s_wd;
  logic        s_read, s_write;
  logic [3:0]  s_be;

  logic        f_w0, f_w1;
  logic [31:0] f_rd0, f_rd1, f_addr, f_wd;
  logic        f_read, f_write;
  logic [3:0]  f_be;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(w0), .m0_readdata(rd0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(w1), .m1_readdata(rd1),
    .address(s_addr), .read(s_read), .write(s_write), .writedata(s_wd),
    .byteenable(s_be), .waitrequest(s_wait), .readdata(s_rdata)
  );

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b1)) u_fix (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(f_w0), .m0_readdata(f_rd0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(f_w1), .m1_readdata(f_rd1),
    .address(f_addr), .read(f_read), .write(f_write), .writedata(f_wd),
    .byteenable(f_be), .waitrequest(s_wait), .readdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r0, w0;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        r1, w1;
    logic [31:0] a1;
    logic        sw;
    logic [31:0] srd;
    logic        ew0, ew1;
    logic [31:0] erd0, erd1;
    logic        erq, ewq;
    logic [31:0] eaddr, ewd;
    logic [3:0]  ebe;
  } vec_t;

  function automatic vec_t V(string n,
      logic r0, logic w0x, logic [31:0] a0, logic [31:0] wd0, logic [3:0] be0,
      logic r1, logic w1x, logic [31:0] a1, logic sw, logic [31:0] srd,
      logic ew0, logic ew1, logic [31:0] erd0, logic [31:0] erd1,
      logic erq, logic ewq, logic [31:0] eaddr, logic [31:0] ewd, logic [3:0] ebe);
    vec_t v;
    v.name = n; v.r0 = r0; v.w0 = w0x; v.a0 = a0; v.wd0 = wd0; v.be0 = be0;
    v.r1 = r1; v.w1 = w1x; v.a1 = a1; v.sw = sw; v.srd = srd;
    v.ew0 = ew0; v.ew1 = ew1; v.erd0 = erd0; v.erd1 = erd1;
    v.erq = erq; v.ewq = ewq; v.eaddr = eaddr; v.ewd = ewd; v.ebe = ebe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    m1_read = 0; m1_write = 0; m1_address = 0;
    s_wait = 0; s_rdata = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    @(posedge clk);
    #1;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0;
    m0_writedata = v.wd0; m0_byteenable = v.be0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1;
    s_wait = v.sw; s_rdata = v.srd;
    @(negedge clk);
    chk({v.name, ".m0_wait"}, {31'd0, w0}, {31'd0, v.ew0});
    chk({v.name, ".m1_wait"}, {31'd0, w1}, {31'd0, v.ew1});
    chk({v.name, ".m0_rdata"}, rd0, v.erd0);
    chk({v.name, ".m1_rdata"}, rd1, v.erd1);
    chk({v.name, ".read"}, {31'd0, s_read}, {31'd0, v.erq});
    chk({v.name, ".write"}, {31'd0, s_write}, {31'd0, v.ewq});
    chk({v.name, ".addr"}, s_addr, v.eaddr);
    chk({v.name, ".wdata"}, s_wd, v.ewd);
    chk({v.name, ".be"}, {28'd0, s_be}, {28'd0, v.ebe});
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    m1_writedata  = 32'h0000_0055;
    m1_byteenable = 4'h3;
    drive_idle();

    // m1 read, zero-wait slave
    vecs.push_back(V("c0_req", 0,0,0,0,0, 1,0,32'hBFC00000, 0,0, 1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c1_m1done", 0,0,0,0,0, 1,0,32'hBFC00000, 0,32'h24020090,
                     1,0,0,32'h24020090, 1,0,32'hBFC00000,32'h55,4'h3));
    vecs.push_back(V("c2_idle", 0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0, 0,0,0,0,0));
    // m0 write stalled three cycles, writedata changed mid-stall
    vecs.push_back(V("c3_wreq", 0,1,32'h1000,32'h90,4'hF, 0,0,0, 0,0, 1,1,0,0, 0,0,0,0,0));
    for (int i = 4; i <= 6; i++)
      vecs.push_back(V($sformatf("c%0d_stall", i), 0,1,32'h1000,32'hDEADBEEF,4'hF, 0,0,0,
                       1,32'h11111111, 1,1,0,0, 0,1,32'h1000,32'h90,4'hF));
    vecs.push_back(V("c7_wdone", 0,1,32'h1000,32'hDEADBEEF,4'hF, 0,0,0, 0,0,
                     0,1,0,0, 0,1,32'h1000,32'h90,4'hF));
    vecs.push_back(V("c8_idle", 0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0, 0,0,0,0,0));
    // both request continuously; rr_ptr now favours m1
    vecs.push_back(V("c9_both", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,0, 1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c10_m1", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hAAAA0001,
                     1,0,0,32'hAAAA0001, 1,0,32'hBFC00004,32'h55,4'h3));
    vecs.push_back(V("c11_arb", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hAAAA0001,
                     1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c12_m0", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hBBBB0002,
                     0,1,32'hBBBB0002,0, 1,0,32'h2000,0,4'hF));
    vecs.push_back(V("c13_arb", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hBBBB0002,
                     1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c14_m1", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hCCCC0003,
                     1,0,0,32'hCCCC0003, 1,0,32'hBFC00004,32'h55,4'h3));
    vecs.push_back(V("c15_arb", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,0, 1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c16_m0", 1,0,32'h2000,0,4'hF, 1,0,32'hBFC00004, 0,32'hDDDD0004,
                     0,1,32'hDDDD0004,0, 1,0,32'h2000,0,4'hF));
    // m1 asserts read and write together: slave must see a write
    vecs.push_back(V("c17_rw", 0,0,0,0,0, 1,1,32'h3000, 0,0, 1,1,0,0, 0,0,0,0,0));
    vecs.push_back(V("c18_rwstall", 0,0,0,0,0, 1,1,32'h3000, 1,0,
                     1,1,0,0, 0,1,32'h3000,32'h55,4'h3));

    // asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst0.read", {31'd0, s_read}, 32'd0);
    chk("rst0.write", {31'd0, s_write}, 32'd0);
    chk("rst0.addr", s_addr, 32'd0);
    chk("rst0.m0_wait", {31'd0, w0}, 32'd1);
    chk("rst0.m1_wait", {31'd0, w1}, 32'd1);
    chk("rst0.m0_rdata", rd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // reset mid-stall, between clock edges
    #2 reset = 1'b1;
    #1;
    chk("rst1.write", {31'd0, s_write}, 32'd0);
    chk("rst1.read", {31'd0, s_read}, 32'd0);
    chk("rst1.addr", s_addr, 32'd0);
    chk("rst1.wdata", s_wd, 32'd0);
    chk("rst1.m1_wait", {31'd0, w1}, 32'd1);
    chk("rst1.m1_rdata", rd1, 32'd0);
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // both request after reset: rr_ptr is back at m0; fixed instance keeps choosing m0
    apply_vec(V("p0_both", 1,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,0, 1,1,0,0, 0,0,0,0,0));
    apply_vec(V("p1_m0", 1,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,32'h5,
                0,1,32'h5,0, 1,0,32'h5000,0,4'hF));
    chk("p1.fix_addr", f_addr, 32'h5000);
    chk("p1.fix_m0_wait", {31'd0, f_w0}, 32'd0);
    chk("p1.fix_m0_rdata", f_rd0, 32'h5);
    apply_vec(V("p2_arb", 1,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,0, 1,1,0,0, 0,0,0,0,0));
    chk("p2.fix_read", {31'd0, f_read}, 32'd0);
    apply_vec(V("p3_m1", 1,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,32'h6,
                1,0,0,32'h6, 1,0,32'h6000,32'h55,4'h3));
    chk("p3.fix_addr", f_addr, 32'h5000);
    chk("p3.fix_m0_wait", {31'd0, f_w0}, 32'd0);
    chk("p3.fix_m1_wait", {31'd0, f_w1}, 32'd1);
    chk("p3.fix_m1_rdata", f_rd1, 32'd0);
    apply_vec(V("p4_m1only", 0,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,0, 1,1,0,0, 0,0,0,0,0));
    apply_vec(V("p5_m1", 0,0,32'h5000,0,4'hF, 1,0,32'h6000, 0,32'h7,
                1,0,0,32'h7, 1,0,32'h6000,32'h55,4'h3));
    chk("p5.fix_addr", f_addr, 32'h6000);
    chk("p5.fix_m1_wait", {31'd0, f_w1}, 32'd0);
    chk("p5.fix_m1_rdata", f_rd1, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master to one-slave arbiter for the CPU's Avalon memory-mapped bus. It lets the data-access port (m0) and the instruction-fetch port (m1) share the single RAM slave. Round-robin (or fixed-priority) grant is held for exactly one complete transaction. The command is latched at grant, so the slave sees stable signals for the whole waitrequest stall.

## Interface
- FIXED_PRIORITY, default 0: 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- m0_address / m1_address  in  32  byte address from requester.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  stall to requester; low for exactly the completing cycle.
- m0_readdata / m1_readdata  out  32  read data, valid when own waitrequest low after a read.
- address  out  32  to RAM slave.
- read, write  out  1  to RAM slave.
- writedata  out  32  to RAM slave.
- byteenable  out  4  to RAM slave.
- waitrequest  in  1  from RAM slave.
- readdata  in  32  from RAM slave.

## Operation
- States: IDLE, BUSY0, BUSY1. rr_ptr (1 bit) names the master favoured on the next tie; reset value 0 (m0).
- A master requests when read|write is high. If a master asserts both, the arbiter treats it as a write and forces read=0 in the latched command.
- In IDLE with m0 requesting only, go to BUSY0. With m1 requesting only, go to BUSY1.
- In IDLE with both requesting: FIXED_PRIORITY=1 selects m0; otherwise the master named by rr_ptr wins.
- On the grant edge, latch the winner's address, read, write, writedata and byteenable into a command register.
- In BUSYn, slave outputs come from the command register, not from the live master inputs. Master changes mid-transaction have no effect.
- In BUSYn, mn_waitrequest equals slave waitrequest.
- In BUSYn, the cycle with waitrequest=0 completes the transaction:
  - mn_readdata = readdata (combinational pass-through).
  - Next state is IDLE.
  - If FIXED_PRIORITY=0, rr_ptr becomes the other master.
- mn_waitrequest=1 in every other case: IDLE, or the other master's grant.
- mn_readdata=0 when not completing.
- In IDLE the slave outputs are all zero: address, read, write, writedata, byteenable.
- No back-to-back grant. Every transaction passes through IDLE for one cycle, which is the arbitration cycle.

## Timing
- Reset values: state IDLE, rr_ptr 0, command register 0. All slave outputs 0, m0/m1_waitrequest 1, m0/m1_readdata 0.
- Reset asserted mid-transaction:
  - Outputs take their reset values asynchronously.
  - The in-flight transaction is abandoned and no completion is signalled.
  - A write already visible to the slave may have been taken.
- Minimum latency is 2 cycles: request sampled in IDLE at edge k, slave command visible after edge k, completion in cycle k+1 if slave waitrequest=0.
- Each slave waitrequest=1 cycle adds one cycle.
- Sustained throughput with a zero-wait slave is one transaction per 2 cycles.
- A losing master stays stalled with waitrequest=1. It must hold its request under Avalon rules and is granted at the next IDLE.
- Round-robin starvation bound: at most one foreign transaction between a master's request and its grant.

## Test plan
- Reset: assert reset mid-cycle with no clock edge. Outputs go immediately to read=write=0, address=0, m0/m1_waitrequest=1.
- Single read, zero-wait: m1 reads 0xBFC00000 and the slave returns 0x24020090.
  - The slave sees read=1 one cycle after the request.
  - m1_waitrequest is low in the second cycle with m1_readdata=0x24020090.
  - m0_waitrequest stays 1 throughout.
- Stalled write: m0 writes 0x00000090 to 0x00001000 with byteenable 0xF, and the slave holds waitrequest=1 for 3 cycles.
  - The slave command stays stable for all 4 cycles, even though m0_writedata is changed to 0xDEADBEEF during the stall.
  - m0 completes in cycle 5.
- Simultaneous requests, round-robin: m0 and m1 request continuously from reset.
  - Grants alternate m0, m1, m0, m1.
  - Each completion is 2 cycles apart with a zero-wait slave.
- FIXED_PRIORITY=1: m0 and m1 request together.
  - m0 wins every arbitration while it keeps requesting.
  - m1 is granted on the first IDLE where m0 is not requesting.
- Read+write together, then reset mid-stall:
  - m1 asserts read=1 and write=1; the slave sees write=1, read=0.
  - Reset during the stall drops the slave write and returns to IDLE.
  - The next request is granted normally.
